// File: rtl/hdlc_tx_bitstream.sv
// rtl/hdlc_tx_bitstream.sv - HDLC transmit serialiser with flags, zero insertion and abort
module hdlc_tx_bitstream #(
  parameter logic IDLE_BIT = 1'b1
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Tx_Enable,
  input  logic       Tx_DataAvail,
  input  logic [7:0] Tx_Data,
  input  logic       Tx_AbortFrame,
  output logic       Tx_RdBuff,
  output logic       Tx_NewByte,
  output logic       Tx_ValidFrame,
  output logic       Tx_AbortedTrans,
  output logic       Tx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLAG_OPEN,
    S_DATA,
    S_FLAG_CLOSE,
    S_ABORT
  } state_t;

  // Flag 01111110 as sent LSB first.
  localparam logic [7:0] FLAG = 8'h7E;

  // state_q/cnt_q describe the item bit currently on Tx; during a stuff
  // cycle cnt_q holds the index of the data bit just sent.
  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [2:0] ones_q, ones_d;
  logic       stuff_q, stuff_d;
  logic       close_q, close_d;
  logic       rd_wait_q, rd_wait_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] hold_q, hold_d;
  logic       tx_q, tx_d;
  logic       valid_q, valid_d;
  logic       newbyte_q, newbyte_d;
  logic       aborted_q, aborted_d;
  logic       rd_buff;
  logic [2:0] cnt_inc;
  logic [7:0] next_byte;

  // Next-bit selection: framing, byte fetch, zero insertion and abort.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ones_d    = ones_q;
    stuff_d   = 1'b0;
    close_d   = close_q;
    rd_wait_d = 1'b0;
    shift_d   = shift_q;
    hold_d    = hold_q;
    tx_d      = tx_q;
    valid_d   = valid_q;
    newbyte_d = 1'b0;
    aborted_d = 1'b0;
    rd_buff   = 1'b0;
    cnt_inc   = cnt_q + 3'd1;
    // A byte popped last cycle is still on Tx_Data; use it directly if the
    // item ends now, otherwise it waits in the holding register.
    next_byte = rd_wait_q ? Tx_Data : hold_q;
    if (rd_wait_q) begin
      hold_d = Tx_Data;
    end

    case (state_q)
      S_IDLE: begin
        tx_d    = IDLE_BIT;
        valid_d = 1'b0;
        cnt_d   = 3'd0;
        ones_d  = 3'd0;
        close_d = 1'b0;
        if (Tx_Enable && Tx_DataAvail) begin
          state_d = S_FLAG_OPEN;
          tx_d    = FLAG[0];
          valid_d = 1'b1;
        end
      end

      S_ABORT: begin
        if (cnt_q == 3'd7) begin
          state_d = S_IDLE;
          cnt_d   = 3'd0;
          tx_d    = IDLE_BIT;
        end else begin
          cnt_d = cnt_inc;
          tx_d  = 1'b1;
        end
      end

      default: begin
        if (Tx_AbortFrame) begin
          state_d   = S_ABORT;
          cnt_d     = 3'd0;
          ones_d    = 3'd0;
          tx_d      = 1'b0;
          valid_d   = 1'b0;
          aborted_d = 1'b1;
        end else begin
          // Decide at bit 6 whether another byte follows this item.
          if (state_q != S_FLAG_CLOSE && cnt_q == 3'd6 && !stuff_q) begin
            if (Tx_DataAvail) begin
              rd_buff   = 1'b1;
              rd_wait_d = 1'b1;
            end else begin
              close_d = 1'b1;
            end
          end

          if (state_q == S_DATA && !stuff_q && ones_q == 3'd5) begin
            stuff_d = 1'b1;
            tx_d    = 1'b0;
            ones_d  = 3'd0;
          end else if (cnt_q != 3'd7) begin
            cnt_d = cnt_inc;
            if (state_q == S_DATA) begin
              tx_d   = shift_q[cnt_inc];
              ones_d = shift_q[cnt_inc] ? ones_q + 3'd1 : 3'd0;
            end else begin
              tx_d   = FLAG[cnt_inc];
              ones_d = 3'd0;
            end
          end else begin
            cnt_d = 3'd0;
            if (state_q == S_FLAG_CLOSE) begin
              state_d = S_IDLE;
              tx_d    = IDLE_BIT;
              valid_d = 1'b0;
            end else if (close_q) begin
              state_d = S_FLAG_CLOSE;
              tx_d    = FLAG[0];
              ones_d  = 3'd0;
            end else begin
              state_d   = S_DATA;
              shift_d   = next_byte;
              tx_d      = next_byte[0];
              ones_d    = next_byte[0] ? ones_q + 3'd1 : 3'd0;
              newbyte_d = 1'b1;
            end
          end
        end
      end
    endcase
  end

  // State and registered line outputs.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 3'd0;
      ones_q    <= 3'd0;
      stuff_q   <= 1'b0;
      close_q   <= 1'b0;
      rd_wait_q <= 1'b0;
      shift_q   <= 8'd0;
      hold_q    <= 8'd0;
      tx_q      <= IDLE_BIT;
      valid_q   <= 1'b0;
      newbyte_q <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ones_q    <= ones_d;
      stuff_q   <= stuff_d;
      close_q   <= close_d;
      rd_wait_q <= rd_wait_d;
      shift_q   <= shift_d;
      hold_q    <= hold_d;
      tx_q      <= tx_d;
      valid_q   <= valid_d;
      newbyte_q <= newbyte_d;
      aborted_q <= aborted_d;
    end
  end

  assign Tx_RdBuff       = rd_buff && !Rst;
  assign Tx_NewByte      = newbyte_q;
  assign Tx_ValidFrame   = valid_q;
  assign Tx_AbortedTrans = aborted_q;
  assign Tx              = tx_q;

endmodule

// File: tb/tb_hdlc_tx_bitstream.sv
// tb/tb_hdlc_tx_bitstream.sv - scoreboard bench for hdlc_tx_bitstream
module tb_hdlc_tx_bitstream;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       Tx_Enable = 1'b0;
  logic       Tx_DataAvail = 1'b0;
  logic [7:0] Tx_Data = 8'd0;
  logic       Tx_AbortFrame = 1'b0;
  logic       Tx_RdBuff, Tx_NewByte, Tx_ValidFrame, Tx_AbortedTrans, Tx;

  int n_cmp = 0;
  int n_bad = 0;
  int rd_cnt = 0;
  bit mon_off = 1'b1;
  bit in_frame = 1'b0;

  // Expected per-cycle tuple {Tx, Tx_ValidFrame, Tx_NewByte, Tx_AbortedTrans}.
  logic [3:0] exp_q[$];
  logic [7:0] bq[$];
  logic [7:0] cur_bytes[$];

  hdlc_tx_bitstream #(.IDLE_BIT(1'b1)) dut (
    .Clk            (Clk),
    .Rst            (Rst),
    .Tx_Enable      (Tx_Enable),
    .Tx_DataAvail   (Tx_DataAvail),
    .Tx_Data        (Tx_Data),
    .Tx_AbortFrame  (Tx_AbortFrame),
    .Tx_RdBuff      (Tx_RdBuff),
    .Tx_NewByte     (Tx_NewByte),
    .Tx_ValidFrame  (Tx_ValidFrame),
    .Tx_AbortedTrans(Tx_AbortedTrans),
    .Tx             (Tx)
  );

  always #5 Clk = ~Clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h at t=%0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Reference frame: flag, data LSB first with a 0 after every run of five
  // data ones, flag, one idle cycle; an abort truncates after abort_at.
  function automatic void build(input int abort_at);
    logic [3:0] f[$];
    logic [7:0] flag;
    logic [7:0] cb;
    int ones;
    flag = 8'h7E;
    ones = 0;
    for (int i = 0; i < 8; i++) f.push_back({flag[i], 1'b1, 2'b00});
    foreach (cur_bytes[k]) begin
      cb = cur_bytes[k];
      for (int i = 0; i < 8; i++) begin
        f.push_back({cb[i], 1'b1, (i == 0), 1'b0});
        ones = cb[i] ? ones + 1 : 0;
        if (ones == 5) begin
          f.push_back(4'b0100);
          ones = 0;
        end
      end
    end
    for (int i = 0; i < 8; i++) f.push_back({flag[i], 1'b1, 2'b00});
    if (abort_at >= 0) begin
      while (f.size() > abort_at + 1) void'(f.pop_back());
      f.push_back(4'b0001);
      for (int i = 0; i < 7; i++) f.push_back(4'b1000);
    end
    f.push_back(4'b1000);
    foreach (f[i]) exp_q.push_back(f[i]);
  endfunction

  // Tx buffer model: pops on Tx_RdBuff, data valid from the next cycle.
  initial begin
    bit pop;
    forever begin
      @(negedge Clk);
      pop = Tx_RdBuff;
      @(posedge Clk);
      #1;
      if (pop) begin
        rd_cnt++;
        if (bq.size() > 0) Tx_Data = bq.pop_front();
      end
      Tx_DataAvail = (bq.size() != 0);
    end
  end

  // Monitor: compare every cycle of a frame against the scoreboard, idle otherwise.
  initial begin
    logic [3:0] e;
    forever begin
      @(negedge Clk);
      if (mon_off) begin
        in_frame = 1'b0;
      end else begin
        if (!in_frame && exp_q.size() > 0 && Tx_ValidFrame) in_frame = 1'b1;
        if (in_frame && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("tx_tuple", int'({Tx, Tx_ValidFrame, Tx_NewByte, Tx_AbortedTrans}), int'(e));
          if (exp_q.size() == 0) in_frame = 1'b0;
        end else begin
          in_frame = 1'b0;
          check("idle", int'({Tx_RdBuff, Tx, Tx_ValidFrame, Tx_NewByte, Tx_AbortedTrans}), int'(5'b01000));
        end
      end
    end
  end

  task automatic start_frame(input int abort_at, input bit model);
    foreach (cur_bytes[i]) bq.push_back(cur_bytes[i]);
    if (model) build(abort_at);
    tick();
    tick();
    Tx_Enable = 1'b1;
    tick();
    Tx_Enable = 1'b0;
  endtask

  task automatic wait_done(input int exp_rd, input int rd0, input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 600) begin
      tick();
      t++;
    end
    check({name, "_complete"}, int'(exp_q.size() == 0), 1);
    exp_q.delete();
    repeat (3) tick();
    check({name, "_rdbuff_count"}, rd_cnt - rd0, exp_rd);
  endtask

  initial begin
    int rd0;
    int t;
    int n;
    int pick;

    Rst = 1'b1;
    tick();
    @(negedge Clk);
    check("reset_outputs", int'({Tx_RdBuff, Tx, Tx_ValidFrame, Tx_NewByte, Tx_AbortedTrans}), int'(5'b01000));
    tick();
    Rst = 1'b0;
    mon_off = 1'b0;

    repeat (40) tick();

    Tx_AbortFrame = 1'b1;
    tick();
    Tx_AbortFrame = 1'b0;
    repeat (3) tick();

    cur_bytes = '{8'h55};
    rd0 = rd_cnt;
    start_frame(-1, 1'b1);
    wait_done(1, rd0, "byte55");

    cur_bytes = '{8'hFF, 8'h0F};
    rd0 = rd_cnt;
    start_frame(-1, 1'b1);
    wait_done(2, rd0, "stuff_ff0f");

    cur_bytes = '{8'h7E};
    rd0 = rd_cnt;
    start_frame(-1, 1'b1);
    wait_done(1, rd0, "byte7e");

    cur_bytes = '{8'hAA, 8'hAA, 8'hAA};
    rd0 = rd_cnt;
    start_frame(19, 1'b1);
    t = 0;
    @(negedge Clk);
    while (!Tx_ValidFrame && t < 20) begin
      @(negedge Clk);
      t++;
    end
    check("abort_frame_start", int'(Tx_ValidFrame), 1);
    repeat (19) @(negedge Clk);
    Tx_AbortFrame = 1'b1;
    @(negedge Clk);
    Tx_AbortFrame = 1'b0;
    repeat (2) @(negedge Clk);
    Tx_AbortFrame = 1'b1;
    @(negedge Clk);
    Tx_AbortFrame = 1'b0;
    wait_done(2, rd0, "abort");
    bq.delete();
    repeat (3) tick();

    mon_off = 1'b1;
    cur_bytes = '{8'h3C, 8'h5A};
    start_frame(-1, 1'b0);
    repeat (10) tick();
    Rst = 1'b1;
    tick();
    @(negedge Clk);
    check("reset_mid_frame", int'({Tx_RdBuff, Tx, Tx_ValidFrame, Tx_NewByte, Tx_AbortedTrans}), int'(5'b01000));
    tick();
    Rst = 1'b0;
    bq.delete();
    exp_q.delete();
    repeat (3) tick();
    mon_off = 1'b0;
    cur_bytes = '{8'h3C};
    rd0 = rd_cnt;
    start_frame(-1, 1'b1);
    wait_done(1, rd0, "after_reset");

    for (int f = 0; f < 10; f++) begin
      cur_bytes.delete();
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        pick = $urandom_range(0, 3);
        cur_bytes.push_back(pick == 0 ? 8'hFF : pick == 1 ? 8'h7E : 8'($urandom));
      end
      rd0 = rd_cnt;
      start_frame(-1, 1'b1);
      wait_done(n, rd0, "random");
      repeat ($urandom_range(0, 4)) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
